// File: rtl/arp_static_resolver.sv
// Static-table ARP responder: resolves a next-hop IPv4 address to a MAC using a
// software-programmed table, with broadcast/multicast mapped arithmetically.
module arp_static_resolver #(
   parameter int TABLE_SIZE  = 8,
   parameter int INDEX_WIDTH = $clog2(TABLE_SIZE)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   arp_request_valid,
   output logic                   arp_request_ready,
   input  logic [31:0]            arp_request_ip,
   output logic                   arp_response_valid,
   input  logic                   arp_response_ready,
   output logic                   arp_response_error,
   output logic [47:0]            arp_response_mac,
   input  logic                   tbl_wr_en,
   input  logic [INDEX_WIDTH-1:0] tbl_wr_addr,
   input  logic [31:0]            tbl_wr_ip,
   input  logic [47:0]            tbl_wr_mac,
   input  logic                   tbl_wr_valid,
   input  logic                   clear_table,
   input  logic [31:0]            local_ip,
   input  logic [31:0]            gateway_ip,
   input  logic [31:0]            subnet_mask,
   output logic                   busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic [INDEX_WIDTH-1:0] IDX_LAST = INDEX_WIDTH'(TABLE_SIZE - 1);

   state_t                 state_q;
   logic                   ready_q;
   logic                   valid_q;
   logic                   error_q;
   logic [47:0]            mac_q;
   logic [31:0]            target_q;
   logic [INDEX_WIDTH-1:0] idx_q;

   logic [TABLE_SIZE-1:0]  tbl_vld_q;
   logic [31:0]            tbl_ip_q  [TABLE_SIZE];
   logic [47:0]            tbl_mac_q [TABLE_SIZE];

   logic                   on_subnet_s;
   logic                   bcast_s;
   logic                   mcast_s;
   logic                   no_route_s;
   logic [31:0]            target_d;
   logic                   hit_s;

   assign arp_request_ready  = ready_q;
   assign arp_response_valid = valid_q;
   assign arp_response_error = error_q;
   assign arp_response_mac   = mac_q;
   assign busy               = (state_q != S_IDLE);

   // The compare reads the registered table, so a same-cycle write or clear is not seen.
   assign hit_s = tbl_vld_q[idx_q] && (tbl_ip_q[idx_q] == target_q);

   // Classify the incoming request against the live configuration inputs.
   always_comb begin
      on_subnet_s = 1'b0;
      bcast_s     = 1'b0;
      mcast_s     = 1'b0;
      no_route_s  = 1'b0;
      target_d    = arp_request_ip;
      on_subnet_s = (((arp_request_ip ^ local_ip) & subnet_mask) == 32'h0000_0000);
      bcast_s     = (arp_request_ip == 32'hFFFF_FFFF) ||
                    (on_subnet_s && ((arp_request_ip | subnet_mask) == 32'hFFFF_FFFF));
      mcast_s     = (arp_request_ip[31:28] == 4'hE);
      if (on_subnet_s) begin
         target_d   = arp_request_ip;
         no_route_s = 1'b0;
      end else if (gateway_ip != 32'h0000_0000) begin
         target_d   = gateway_ip;
         no_route_s = 1'b0;
      end else begin
         target_d   = arp_request_ip;
         no_route_s = 1'b1;
      end
   end

   // Lookup FSM with registered handshake and response outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         ready_q  <= 1'b0;
         valid_q  <= 1'b0;
         error_q  <= 1'b0;
         mac_q    <= 48'h0;
         target_q <= 32'h0;
         idx_q    <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               ready_q <= 1'b1;
               if (arp_request_valid && ready_q) begin
                  ready_q <= 1'b0;
                  if (bcast_s) begin
                     mac_q   <= 48'hFFFF_FFFF_FFFF;
                     error_q <= 1'b0;
                     valid_q <= 1'b1;
                     state_q <= S_RESP;
                  end else if (mcast_s) begin
                     mac_q   <= {24'h01005E, 1'b0, arp_request_ip[22:0]};
                     error_q <= 1'b0;
                     valid_q <= 1'b1;
                     state_q <= S_RESP;
                  end else if (no_route_s) begin
                     mac_q   <= 48'h0;
                     error_q <= 1'b1;
                     valid_q <= 1'b1;
                     state_q <= S_RESP;
                  end else begin
                     target_q <= target_d;
                     idx_q    <= '0;
                     state_q  <= S_SCAN;
                  end
               end
            end
            S_SCAN: begin
               if (hit_s) begin
                  mac_q   <= tbl_mac_q[idx_q];
                  error_q <= 1'b0;
                  valid_q <= 1'b1;
                  state_q <= S_RESP;
               end else if (idx_q == IDX_LAST) begin
                  mac_q   <= 48'h0;
                  error_q <= 1'b1;
                  valid_q <= 1'b1;
                  state_q <= S_RESP;
               end else begin
                  idx_q <= idx_q + INDEX_WIDTH'(1);
               end
            end
            S_RESP: begin
               if (arp_response_ready) begin
                  valid_q <= 1'b0;
                  error_q <= 1'b0;
                  mac_q   <= 48'h0;
                  ready_q <= 1'b1;
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
               ready_q <= 1'b0;
               valid_q <= 1'b0;
               error_q <= 1'b0;
               mac_q   <= 48'h0;
            end
         endcase
      end
   end

   // Entry valid bits; clear_table wins over a same-cycle write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tbl_vld_q <= '0;
      end else if (clear_table) begin
         tbl_vld_q <= '0;
      end else if (tbl_wr_en) begin
         tbl_vld_q[tbl_wr_addr] <= tbl_wr_valid;
      end
   end

   // Entry payload, meaningless while its valid bit is clear so left unreset.
   always_ff @(posedge clk) begin
      if (tbl_wr_en) begin
         tbl_ip_q[tbl_wr_addr]  <= tbl_wr_ip;
         tbl_mac_q[tbl_wr_addr] <= tbl_wr_mac;
      end
   end

endmodule

// File: tb/tb_arp_static_resolver.sv
// Directed self-checking bench for arp_static_resolver (TABLE_SIZE = 8).
module tb_arp_static_resolver;

   logic        clk;
   logic        rst_n;
   logic        arp_request_valid;
   logic        arp_request_ready;
   logic [31:0] arp_request_ip;
   logic        arp_response_valid;
   logic        arp_response_ready;
   logic        arp_response_error;
   logic [47:0] arp_response_mac;
   logic        tbl_wr_en;
   logic [2:0]  tbl_wr_addr;
   logic [31:0] tbl_wr_ip;
   logic [47:0] tbl_wr_mac;
   logic        tbl_wr_valid;
   logic        clear_table;
   logic [31:0] local_ip;
   logic [31:0] gateway_ip;
   logic [31:0] subnet_mask;
   logic        busy;

   int checks = 0;
   int errors = 0;

   arp_static_resolver #(.TABLE_SIZE(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .arp_request_valid(arp_request_valid), .arp_request_ready(arp_request_ready),
      .arp_request_ip(arp_request_ip),
      .arp_response_valid(arp_response_valid), .arp_response_ready(arp_response_ready),
      .arp_response_error(arp_response_error), .arp_response_mac(arp_response_mac),
      .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_ip(tbl_wr_ip),
      .tbl_wr_mac(tbl_wr_mac), .tbl_wr_valid(tbl_wr_valid), .clear_table(clear_table),
      .local_ip(local_ip), .gateway_ip(gateway_ip), .subnet_mask(subnet_mask),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] ip, input logic [47:0] mac,
                     input logic v);
      tbl_wr_en = 1'b1; tbl_wr_addr = a; tbl_wr_ip = ip; tbl_wr_mac = mac; tbl_wr_valid = v;
      step();
      tbl_wr_en = 1'b0;
   endtask

   // Present a request and return right after the accept edge.
   task automatic accept(input string tag, input logic [31:0] ip);
      int n;
      n = 0;
      arp_request_ip = ip;
      arp_request_valid = 1'b1;
      while (!arp_request_ready && n < 50) begin
         step();
         n++;
      end
      chk({tag, "_accept_timeout"}, 64'(n < 50), 64'd1);
      step();
      arp_request_valid = 1'b0;
   endtask

   // Called just after the accept edge; latency 1 means valid is already high.
   task automatic wait_resp(input int start, output int lat);
      lat = start;
      while (!arp_response_valid && lat < 40) begin
         step();
         lat++;
      end
   endtask

   task automatic finish_resp(input string tag, input int lat, input int exp_lat,
                              input logic exp_err, input logic [47:0] exp_mac);
      chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      chk({tag, "_err"}, 64'(arp_response_error), 64'(exp_err));
      chk({tag, "_mac"}, 64'(arp_response_mac), 64'(exp_mac));
      chk({tag, "_rdy_low"}, 64'(arp_request_ready), 64'd0);
      arp_response_ready = 1'b1;
      step();
      arp_response_ready = 1'b0;
      chk({tag, "_valid_drop"}, 64'(arp_response_valid), 64'd0);
      chk({tag, "_rdy_back"}, 64'(arp_request_ready), 64'd1);
   endtask

   task automatic lookup(input string tag, input logic [31:0] ip, input int exp_lat,
                         input logic exp_err, input logic [47:0] exp_mac);
      int lat;
      accept(tag, ip);
      wait_resp(1, lat);
      finish_resp(tag, lat, exp_lat, exp_err, exp_mac);
   endtask

   initial begin
      int lat;
      rst_n = 1'b0;
      arp_request_valid = 1'b0; arp_request_ip = 32'h0; arp_response_ready = 1'b0;
      tbl_wr_en = 1'b0; tbl_wr_addr = 3'd0; tbl_wr_ip = 32'h0; tbl_wr_mac = 48'h0;
      tbl_wr_valid = 1'b0; clear_table = 1'b0;
      local_ip = 32'hC0A8_0101; subnet_mask = 32'hFFFF_FF00; gateway_ip = 32'hC0A8_01FE;
      #22;
      chk("rst_ready", 64'(arp_request_ready), 64'd0);
      chk("rst_valid", 64'(arp_response_valid), 64'd0);
      chk("rst_err", 64'(arp_response_error), 64'd0);
      chk("rst_mac", 64'(arp_response_mac), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rel_ready_still_low", 64'(arp_request_ready), 64'd0);
      step();
      chk("rel_ready_up", 64'(arp_request_ready), 64'd1);

      wr(3'd3, 32'hC0A8_010A, 48'h0200_0000_000A, 1'b1);
      wr(3'd0, 32'hC0A8_01FE, 48'h0200_0000_00FE, 1'b1);

      lookup("hit_e3", 32'hC0A8_010A, 5, 1'b0, 48'h0200_0000_000A);
      lookup("gw_e0", 32'h0808_0808, 2, 1'b0, 48'h0200_0000_00FE);
      gateway_ip = 32'h0;
      lookup("no_gw", 32'h0808_0808, 1, 1'b1, 48'h0);
      gateway_ip = 32'hC0A8_01FE;
      lookup("subnet_bc", 32'hC0A8_01FF, 1, 1'b0, 48'hFFFF_FFFF_FFFF);
      lookup("all_bc", 32'hFFFF_FFFF, 1, 1'b0, 48'hFFFF_FFFF_FFFF);
      lookup("mcast", 32'hEF81_0203, 1, 1'b0, 48'h0100_5E01_0203);
      lookup("absent", 32'hC0A8_0163, 9, 1'b1, 48'h0);

      wr(3'd2, 32'hC0A8_0132, 48'h0200_0000_0002, 1'b1);
      wr(3'd5, 32'hC0A8_0132, 48'h0200_0000_0005, 1'b1);
      lookup("dup_low", 32'hC0A8_0132, 4, 1'b0, 48'h0200_0000_0002);
      wr(3'd2, 32'hC0A8_0132, 48'h0200_0000_0002, 1'b0);
      lookup("dup_del", 32'hC0A8_0132, 7, 1'b0, 48'h0200_0000_0005);

      // Backpressure with a second request waiting behind the response.
      accept("bp", 32'hC0A8_010A);
      wait_resp(1, lat);
      chk("bp_lat", 64'(lat), 64'd5);
      arp_request_ip = 32'hFFFF_FFFF;
      arp_request_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("bp_hold_valid", 64'(arp_response_valid), 64'd1);
         chk("bp_hold_mac", 64'(arp_response_mac), 64'h0200_0000_000A);
         chk("bp_hold_rdy", 64'(arp_request_ready), 64'd0);
      end
      arp_response_ready = 1'b1;
      step();
      arp_response_ready = 1'b0;
      chk("bp_rdy_after_hs", 64'(arp_request_ready), 64'd1);
      chk("bp_valid_after_hs", 64'(arp_response_valid), 64'd0);
      step();
      arp_request_valid = 1'b0;
      finish_resp("bp_second", 1, 1, 1'b0, 48'hFFFF_FFFF_FFFF);

      // Clear during SCAN, before entry 3 is reached.
      accept("clr", 32'hC0A8_010A);
      clear_table = 1'b1;
      step();
      clear_table = 1'b0;
      wait_resp(2, lat);
      finish_resp("clr", lat, 9, 1'b1, 48'h0);

      // Reset while a response is pending.
      lookup("pre_bc_dummy", 32'hFFFF_FFFF, 1, 1'b0, 48'hFFFF_FFFF_FFFF);
      accept("rst_resp", 32'hFFFF_FFFF);
      chk("rst_resp_valid_pre", 64'(arp_response_valid), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_resp_valid", 64'(arp_response_valid), 64'd0);
      chk("rst_resp_mac", 64'(arp_response_mac), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // Reset mid-SCAN: previously resolvable entry now misses.
      wr(3'd3, 32'hC0A8_010A, 48'h0200_0000_000A, 1'b1);
      accept("rst_scan", 32'hC0A8_010A);
      step();
      chk("rst_scan_busy_pre", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_scan_busy", 64'(busy), 64'd0);
      chk("rst_scan_valid", 64'(arp_response_valid), 64'd0);
      chk("rst_scan_rdy", 64'(arp_request_ready), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      chk("rst_scan_rdy_up", 64'(arp_request_ready), 64'd1);
      lookup("post_rst_miss", 32'hC0A8_010A, 9, 1'b1, 48'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/arp_static_resolver.md
Name: arp_static_resolver

Overview:
- Responder side of the arp_request/arp_response handshake that the IP transmit path issues when it needs a destination MAC.
- Resolves a next-hop IPv4 address to a MAC from a small software-programmed static table. Broadcast and multicast addresses are handled arithmetically.
- Drop-in alternative to the dynamic ARP engine for fixed-topology links (no frame I/O); sits beside the IP module in the IP stack top level.

Parameters:
- TABLE_SIZE, 8, number of static entries; power of two, 2..256.
- INDEX_WIDTH, $clog2(TABLE_SIZE), table index width; derived, do not override.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- arp_request_valid  in  1  lookup request valid.
- arp_request_ready  out  1  resolver can accept a request.
- arp_request_ip  in  32  IP to resolve.
- arp_response_valid  out  1  response valid.
- arp_response_ready  in  1  consumer accepts the response.
- arp_response_error  out  1  resolution failed.
- arp_response_mac  out  48  resolved MAC; 0 when error.
- tbl_wr_en  in  1  table write strobe.
- tbl_wr_addr  in  INDEX_WIDTH  entry index.
- tbl_wr_ip  in  32  entry IP.
- tbl_wr_mac  in  48  entry MAC.
- tbl_wr_valid  in  1  entry valid bit; 0 deletes the entry.
- clear_table  in  1  invalidate all entries.
- local_ip  in  32  local address.
- gateway_ip  in  32  default gateway; 0 means none.
- subnet_mask  in  32  subnet mask.
- busy  out  1  lookup in progress (state != IDLE).

Behaviour:
- Reset: state IDLE, all entry valid bits 0, arp_request_ready 0, arp_response_valid 0, arp_response_error 0, arp_response_mac 0, busy 0.
- arp_request_ready is registered. It rises on the first clk edge after rst_n deasserts and is 1 only in IDLE. Response is never valid in the same cycle as request_ready.
- The table is held in flops. IP/MAC fields need no reset; valid bits do.
- Accept edge E0 (valid && ready):
  - Capture arp_request_ip as R.
  - Sample local_ip, subnet_mask and gateway_ip; later changes do not affect the in-flight lookup.
- Classification at E0, in priority order:
  1. R == 32'hFFFFFFFF, or on-subnet with (R | subnet_mask) == all ones: MAC FF:FF:FF:FF:FF:FF, error 0, go to RESP.
  2. R[31:28] == 4'hE (multicast): MAC {24'h01005E, 1'b0, R[22:0]}, error 0, go to RESP.
  3. Otherwise compute target T:
     - on-subnet ((R ^ local_ip) & subnet_mask) == 0: T = R;
     - off-subnet with gateway_ip != 0: T = gateway_ip;
     - off-subnet with gateway_ip == 0: error 1, MAC 0, go to RESP.
     Then go to SCAN with idx = 0.
- SCAN: each cycle compares entry[idx] (valid && ip == T).
  - Hit at the edge: latch MAC, error 0, go to RESP.
  - Miss with idx == TABLE_SIZE-1: error 1, MAC 0, go to RESP.
  - Otherwise idx + 1. No wrap; exactly one pass; lowest-index match wins.
- Latency, counted from E0 to the first cycle arp_response_valid is high:
  - special cases: 1;
  - hit at entry k: k+2;
  - miss: TABLE_SIZE+1.
- RESP: arp_response_valid high; valid, error and MAC held stable until arp_response_ready. On the handshake edge go to IDLE; request_ready is 1 in the following cycle (no back-to-back accept).
- Table writes:
  - Accepted in any state, effective the next cycle.
  - A write to the entry being compared in the same cycle does not affect that compare (old contents used).
- clear_table:
  - Clears all valid bits at the next edge and has priority over a same-cycle tbl_wr_en.
  - During SCAN, subsequent compares miss.
  - Does not affect a response already in RESP.
- rst_n asserted mid-lookup or mid-RESP: outputs return to reset values immediately (asynchronous); the pending request is dropped and the table is emptied.

Test Plan:
- local 192.168.1.1 /24, entry3 = 192.168.1.10 -> 02:00:00:00:00:0A; request 192.168.1.10 -> response valid 5 cycles after accept, MAC 02:00:00:00:00:0A, error 0.
- Request 8.8.8.8, gateway 192.168.1.254 in entry0 -> gateway MAC, latency 2. Same request with gateway_ip = 0 -> error 1, MAC 0, latency 1.
- Requests 192.168.1.255 and 255.255.255.255 -> FF:FF:FF:FF:FF:FF, latency 1. Request 239.129.2.3 -> 01:00:5E:01:02:03.
- Request 192.168.1.99 (absent), TABLE_SIZE 8 -> error 1, MAC 0, latency 9. Two entries both holding the target (entries 2 and 5) -> entry 2 MAC returned.
- Hold arp_response_ready low 10 cycles while a second request is pending -> response stable, request_ready 0; second request accepted exactly 1 cycle after the handshake.
- clear_table pulsed during SCAN before the matching entry -> error 1. rst_n pulsed mid-SCAN -> response_valid 0 at once, request_ready 1 one edge after release, a prior hit now misses.
